// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoding definitions: FSM states, scan-code constants,
// the event record carried through the FIFO, and small classification helpers.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_t;

  // Prefix bytes
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Lock keys
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;

  // Fake shifts the keyboard wraps around some extended keys
  localparam logic [7:0] SC_FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] SC_FAKE_SHIFT_R = 8'h59;

  // Protocol/status bytes that never describe a key
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Pause/Break sends E1 followed by seven more bytes
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_ignored(input logic [7:0] code);
    return (code == SC_ERR0) || (code == SC_BAT_OK) || (code == SC_ECHO) ||
           (code == SC_ACK) || (code == SC_RESEND) || (code == SC_ERR1);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == SC_FAKE_SHIFT_L) || (code == SC_FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds only when a pop
// happens in the same cycle. The head is read straight from storage.
`timescale 1ns/1ps
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t push_data,
  input  logic       pop,
  output ps2_event_t head,
  output logic       empty,
  output logic       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ps2_event_t       mem_q [DEPTH];
  ps2_event_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Next storage contents and pointers; pointers wrap naturally at DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; empty slots are never presented
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: strobe edge detect, prefix-tracking FSM, lock-key
// LEDs with typematic suppression, last-make register and an event FIFO.
`timescale 1ns/1ps
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_action,
  input  logic [7:0] scan_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic [2:0] ps2_lock_control,
  output logic [7:0] last_code,
  output logic       overflow
);

  logic       key_prev_q;
  ps2_state_t state_q, state_d;
  logic [2:0] pause_cnt_q, pause_cnt_d;
  logic [2:0] lock_q, lock_d;
  logic [2:0] held_q, held_d;
  logic [7:0] last_code_q, last_code_d;
  logic       overflow_q, overflow_d;

  logic       byte_accept;
  logic       emit;
  ps2_event_t emit_ev;
  logic [2:0] lock_sel;
  ps2_event_t fifo_head;
  logic       fifo_empty, fifo_full, pop;

  assign byte_accept = key_action && !key_prev_q;
  assign ev_valid    = !fifo_empty;
  assign pop         = ev_valid && ev_ready;
  assign ev_code     = ev_valid ? fifo_head.code : 8'h00;
  assign ev_ext      = ev_valid && fifo_head.ext;
  assign ev_release  = ev_valid && fifo_head.rel;
  assign ps2_lock_control = lock_q;
  assign last_code   = last_code_q;
  assign overflow    = overflow_q;

  // Prefix FSM: decides the next state and whether this byte emits an event
  always_comb begin
    state_d      = state_q;
    pause_cnt_d  = pause_cnt_q;
    emit         = 1'b0;
    emit_ev.ext  = 1'b0;
    emit_ev.rel  = 1'b0;
    emit_ev.code = scan_code;
    if (byte_accept) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_E0) begin
            state_d = ST_EXT;
          end else if (scan_code == SC_F0) begin
            state_d = ST_BRK;
          end else if (scan_code == SC_E1) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = PAUSE_LEN;
          end else if (!is_ignored(scan_code)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == SC_F0) begin
            state_d = ST_EXT_BRK;
          end else begin
            state_d = ST_IDLE;
            if (!is_fake_shift(scan_code)) begin
              emit        = 1'b1;
              emit_ev.ext = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d     = ST_IDLE;
          emit        = 1'b1;
          emit_ev.rel = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (!is_fake_shift(scan_code)) begin
            emit        = 1'b1;
            emit_ev.ext = 1'b1;
            emit_ev.rel = 1'b1;
          end
        end
        ST_PAUSE: begin
          pause_cnt_d = pause_cnt_q - 3'd1;
          if (pause_cnt_q <= 3'd1) begin
            state_d      = ST_IDLE;
            pause_cnt_d  = 3'd0;
            emit         = 1'b1;
            emit_ev.code = SC_E1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lock toggles, held bits, last make code and sticky overflow
  always_comb begin
    lock_d      = lock_q;
    held_d      = held_q;
    last_code_d = last_code_q;
    overflow_d  = overflow_q;
    case (emit_ev.code)
      SC_CAPS:   lock_sel = 3'b100;
      SC_NUM:    lock_sel = 3'b010;
      SC_SCROLL: lock_sel = 3'b001;
      default:   lock_sel = 3'b000;
    endcase
    if (emit && !emit_ev.ext) begin
      if (!emit_ev.rel) begin
        lock_d = lock_q ^ (lock_sel & ~held_q);
        held_d = held_q | lock_sel;
      end else begin
        held_d = held_q & ~lock_sel;
      end
    end
    if (emit && !emit_ev.rel) begin
      last_code_d = emit_ev.code;
    end
    if (emit && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers; the strobe history tracks key_action even during reset
  always_ff @(posedge CLOCK_50) begin
    key_prev_q <= key_action;
    if (reset) begin
      state_q     <= ST_IDLE;
      pause_cnt_q <= 3'd0;
      lock_q      <= 3'b000;
      held_q      <= 3'b000;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      lock_q      <= lock_d;
      held_q      <= held_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLOCK_50),
    .reset    (reset),
    .push     (emit),
    .push_data(emit_ev),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed scenarios plus a randomized run
// checked against a byte-level reference model of the decoding rules.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_action = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_release, overflow;
  logic [7:0] ev_code, last_code;
  logic [2:0] ps2_lock_control;

  int n_cmp = 0;
  int n_fail = 0;

  // 50 MHz clock
  always #10 clk = ~clk;

  ps2_key_decoder #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .key_action      (key_action),
    .scan_code       (scan_code),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_code         (ev_code),
    .ev_ext          (ev_ext),
    .ev_release      (ev_release),
    .ps2_lock_control(ps2_lock_control),
    .last_code       (last_code),
    .overflow        (overflow)
  );

  // Reference model: prefix flags, a bounded queue of {ext,rel,code} events
  bit         m_prev, m_ext, m_brk, m_ovf, m_pop, m_acc, m_emit, m_fake;
  int         m_pause;
  logic [9:0] m_fifo[$];
  logic [9:0] m_ev;
  logic [7:0] m_b, m_last;
  logic [2:0] m_lock, m_held, m_sel;

  always @(posedge clk) begin
    if (reset) begin
      m_prev = key_action;
      m_ext = 0; m_brk = 0; m_pause = 0; m_ovf = 0;
      m_fifo.delete();
      m_lock = 3'b000; m_held = 3'b000; m_last = 8'h00;
    end else begin
      m_pop  = (m_fifo.size() > 0) && ev_ready;
      m_acc  = key_action && !m_prev;
      m_prev = key_action;
      m_emit = 0;
      m_ev   = 10'h000;
      if (m_acc) begin
        m_b    = scan_code;
        m_fake = (m_b == 8'h12) || (m_b == 8'h59);
        if (m_pause > 0) begin
          m_pause--;
          if (m_pause == 0) begin m_emit = 1; m_ev = 10'h0E1; end
        end else if (m_ext && m_brk) begin
          m_ext = 0; m_brk = 0;
          if (!m_fake) begin m_emit = 1; m_ev = {2'b11, m_b}; end
        end else if (m_ext) begin
          if (m_b == 8'hF0) m_brk = 1;
          else begin
            m_ext = 0;
            if (!m_fake) begin m_emit = 1; m_ev = {2'b10, m_b}; end
          end
        end else if (m_brk) begin
          m_brk = 0; m_emit = 1; m_ev = {2'b01, m_b};
        end else begin
          if (m_b == 8'hE0) m_ext = 1;
          else if (m_b == 8'hF0) m_brk = 1;
          else if (m_b == 8'hE1) m_pause = 7;
          else if (!(m_b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            m_emit = 1; m_ev = {2'b00, m_b};
          end
        end
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_emit) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(m_ev);
        else m_ovf = 1;
        m_sel = (m_ev[7:0] == 8'h58) ? 3'b100 :
                (m_ev[7:0] == 8'h77) ? 3'b010 :
                (m_ev[7:0] == 8'h7E) ? 3'b001 : 3'b000;
        if (m_ev[9:8] == 2'b00) begin
          if ((m_held & m_sel) == 3'b000) m_lock = m_lock ^ m_sel;
          m_held = m_held | m_sel;
        end else if (m_ev[9:8] == 2'b01) begin
          m_held = m_held & ~m_sel;
        end
        if (!m_ev[8]) m_last = m_ev[7:0];
      end
    end
  end

  // Record every event the DUT hands over (valid && ready at the coming edge)
  logic [9:0] got_q[$];
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) got_q.push_back({ev_ext, ev_release, ev_code});
  end

  // Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #2;
    scan_code  = b;
    key_action = 1'b1;
    @(posedge clk); #2;
    key_action = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; key_action = 1'b0; ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #2;
    ev_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #2 ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_action = 1'b0; ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_cmp++; if ({ev_ext, ev_release, ev_code} !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_ev_fields: got %h expected 000", {ev_ext, ev_release, ev_code}); end
    n_cmp++; if (ps2_lock_control !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_lock: got %b expected 000", ps2_lock_control); end
    n_cmp++; if (last_code !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_last_code: got %h expected 00", last_code); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    @(posedge clk); #2;
    reset = 1'b0; ev_ready = 1'b0;
  endtask

  task automatic test_latency();
    @(posedge clk); #2;
    scan_code = 8'h16; key_action = 1'b1;
    @(negedge clk);
    n_cmp++; if (ev_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL no_bypass: got ev_valid %b expected 0", ev_valid); end
    @(posedge clk); #2;
    key_action = 1'b0;
    @(negedge clk);
    n_cmp++; if ({ev_valid, ev_ext, ev_release, ev_code} !== 11'h416) begin n_fail++; $display("[TB] FAIL latency_t1: got %h expected 416", {ev_valid, ev_ext, ev_release, ev_code}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({ev_valid, ev_code} !== 9'h116) begin n_fail++; $display("[TB] FAIL head_holds: got %h expected 116", {ev_valid, ev_code}); end
    n_cmp++; if (last_code !== 8'h16) begin n_fail++; $display("[TB] FAIL latency_last: got %h expected 16", last_code); end
    drain();
  endtask

  task automatic test_make_break();
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    got_q.delete();
    ev_ready = 1'b1;
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    repeat (3) @(posedge clk); #2 ev_ready = 1'b0;
    @(negedge clk);
    exp_q = '{10'h01C, 10'h11C};
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL make_break_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 10'hxxx;
      n_cmp++; if (obs !== exp_q[i]) begin n_fail++; $display("[TB] FAIL make_break_ev%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
    n_cmp++; if (last_code !== 8'h1C) begin n_fail++; $display("[TB] FAIL make_break_last: got %h expected 1C", last_code); end
  endtask

  task automatic test_extended();
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    got_q.delete();
    ev_ready = 1'b1;
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'h12);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h59);
    repeat (3) @(posedge clk); #2 ev_ready = 1'b0;
    @(negedge clk);
    exp_q = '{10'h275, 10'h375};
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL ext_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 10'hxxx;
      n_cmp++; if (obs !== exp_q[i]) begin n_fail++; $display("[TB] FAIL ext_ev%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
    n_cmp++; if (last_code !== 8'h75) begin n_fail++; $display("[TB] FAIL ext_last: got %h expected 75", last_code); end
  endtask

  task automatic test_lock_typematic();
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    got_q.delete();
    ev_ready = 1'b1;
    applyStimulus(8'h58);
    @(negedge clk);
    n_cmp++; if (ps2_lock_control !== 3'b100) begin n_fail++; $display("[TB] FAIL caps_first: got %b expected 100", ps2_lock_control); end
    applyStimulus(8'h58); applyStimulus(8'h58);
    @(negedge clk);
    n_cmp++; if (ps2_lock_control !== 3'b100) begin n_fail++; $display("[TB] FAIL caps_typematic: got %b expected 100", ps2_lock_control); end
    applyStimulus(8'hF0); applyStimulus(8'h58); applyStimulus(8'h58);
    repeat (3) @(posedge clk); #2 ev_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (ps2_lock_control !== 3'b000) begin n_fail++; $display("[TB] FAIL caps_end: got %b expected 000", ps2_lock_control); end
    exp_q = '{10'h058, 10'h058, 10'h058, 10'h158, 10'h058};
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL caps_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 10'hxxx;
      n_cmp++; if (obs !== exp_q[i]) begin n_fail++; $display("[TB] FAIL caps_ev%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq[8];
    ev_ready = 1'b1;
    applyStimulus(8'h77); applyStimulus(8'hF0); applyStimulus(8'h77);
    got_q.delete();
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) applyStimulus(seq[i]);
    repeat (3) @(posedge clk); #2 ev_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("[TB] FAIL pause_count: got %0d expected 1", got_q.size()); end
    n_cmp++; if (got_q.size() > 0 && got_q[0] !== 10'h0E1) begin n_fail++; $display("[TB] FAIL pause_event: got %h expected 0E1", got_q[0]); end
    n_cmp++; if (ps2_lock_control !== 3'b010) begin n_fail++; $display("[TB] FAIL pause_lock: got %b expected 010", ps2_lock_control); end
    n_cmp++; if (last_code !== 8'hE1) begin n_fail++; $display("[TB] FAIL pause_last: got %h expected E1", last_code); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    do_reset();
    got_q.delete();
    applyStimulus(8'h15); applyStimulus(8'h1D); applyStimulus(8'h24); applyStimulus(8'h2D);
    // fifth make arrives together with a pop of the full FIFO
    @(posedge clk); #2;
    scan_code = 8'h2C; key_action = 1'b1; ev_ready = 1'b1;
    @(posedge clk); #2;
    key_action = 1'b0; ev_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL push_pop_full_overflow: got %b expected 0", overflow); end
    drain();
    exp_q = '{10'h015, 10'h01D, 10'h024, 10'h02D, 10'h02C};
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL push_pop_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 10'hxxx;
      n_cmp++; if (obs !== exp_q[i]) begin n_fail++; $display("[TB] FAIL push_pop_ev%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
    got_q.delete();
    applyStimulus(8'h35); applyStimulus(8'h3C); applyStimulus(8'h43); applyStimulus(8'h44);
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL full_no_overflow: got %b expected 0", overflow); end
    applyStimulus(8'h4D);
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL overflow_set: got %b expected 1", overflow); end
    n_cmp++; if (ev_code !== 8'h35) begin n_fail++; $display("[TB] FAIL overflow_head: got %h expected 35", ev_code); end
    drain();
    exp_q = '{10'h035, 10'h03C, 10'h043, 10'h044};
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL overflow_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 10'hxxx;
      n_cmp++; if (obs !== exp_q[i]) begin n_fail++; $display("[TB] FAIL overflow_ev%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_reset_midseq();
    ev_ready = 1'b1;
    got_q.delete();
    applyStimulus(8'hE0);
    @(posedge clk); #2;
    reset = 1'b1; scan_code = 8'h1C; key_action = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 key_action = 1'b0;
    @(negedge clk);
    n_cmp++; if (got_q.size() != 0 || ev_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL held_strobe_accepted: got %0d events valid %b expected 0", got_q.size(), ev_valid); end
    applyStimulus(8'h1C);
    applyStimulus(8'hE1); applyStimulus(8'h14);
    do_reset();
    ev_ready = 1'b1;
    applyStimulus(8'h1C);
    repeat (3) @(posedge clk); #2 ev_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("[TB] FAIL midseq_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (i < got_q.size() && got_q[i] !== 10'h01C) begin n_fail++; $display("[TB] FAIL midseq_ev%0d: got %h expected 01C", i, got_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[12];
    logic [9:0] exp_head;
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h58, 8'h77, 8'h7E, 8'h1C, 8'h75, 8'hAA, 8'h00};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      key_action = ($urandom_range(0, 2) == 0);
      scan_code  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      ev_ready   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 10'h000;
      n_cmp++; if (ev_valid !== (m_fifo.size() > 0)) begin n_fail++; $display("[TB] FAIL rand_valid c%0d: got %b expected %b", c, ev_valid, m_fifo.size() > 0); end
      n_cmp++; if ({ev_ext, ev_release, ev_code} !== exp_head) begin n_fail++; $display("[TB] FAIL rand_head c%0d: got %h expected %h", c, {ev_ext, ev_release, ev_code}, exp_head); end
      n_cmp++; if (ps2_lock_control !== m_lock) begin n_fail++; $display("[TB] FAIL rand_lock c%0d: got %b expected %b", c, ps2_lock_control, m_lock); end
      n_cmp++; if (last_code !== m_last) begin n_fail++; $display("[TB] FAIL rand_last c%0d: got %h expected %h", c, last_code, m_last); end
      n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_overflow c%0d: got %b expected %b", c, overflow, m_ovf); end
    end
    @(posedge clk); #2;
    key_action = 1'b0; ev_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_make_break();
    test_extended();
    test_lock_typematic();
    test_pause();
    test_overflow();
    test_reset_midseq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-002 CLOCK_50  in  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 key_action  in  1  keyboard byte strobe; its rising edge marks scan_code valid.
REQ-005 scan_code  in  8  raw PS/2 set-2 byte.
REQ-006 ev_valid  out  1  FIFO non-empty; head event presented.
REQ-007 ev_ready  in  1  consumer pop; pop occurs when ev_valid && ev_ready.
REQ-008 ev_code  out  8  head event key code; prefixes are stripped.
REQ-009 ev_ext  out  1  head event was E0-prefixed.
REQ-010 ev_release  out  1  head event was a break (F0); 0 means make.
REQ-011 ps2_lock_control  out  3  lock LEDs: [2] caps, [1] num, [0] scroll.
REQ-012 last_code  out  8  code of the most recent make event, for HEX display.
REQ-013 overflow  out  1  sticky flag: an event was dropped on a full FIFO.

Function
REQ-014 Byte acceptance: a byte is accepted in the cycle where key_action=1 and its registered previous value=0; one byte per edge, however long key_action stays high.
REQ-015 FSM states and transitions on an accepted byte:
- IDLE: E0->EXT; F0->BRK; E1->PAUSE (count=7); 00/AA/EE/FA/FE/FF ignored; else emit (code, ext=0, rel=0).
- EXT: F0->EXT_BRK; 12 or 59 (fake shift) -> IDLE, no event; else emit (code, ext=1, rel=0) -> IDLE.
- BRK: emit (code, ext=0, rel=1) -> IDLE.
- EXT_BRK: 12 or 59 -> IDLE, no event; else emit (code, ext=1, rel=1) -> IDLE.
- PAUSE: decrement count per byte; at count 1->0 emit (E1, ext=0, rel=0) -> IDLE; embedded bytes produce no events and no lock effects.
REQ-016 Event latency: the event from a byte accepted at cycle t is visible on ev_* at t+1 if the FIFO was empty.
REQ-017 Lock toggle: a non-extended make of 58 toggles caps, 77 toggles num, 7E toggles scroll; the output changes at t+1.
REQ-018 Typematic suppression: each lock key has a held bit, set on make and cleared on its break; a make while held does not toggle, but is still enqueued.
REQ-019 last_code updates at t+1 on every emitted make event, including E1; break events leave it unchanged.
REQ-020 FIFO: first-in first-out; the head holds until popped; ev_ready is ignored when ev_valid=0.
REQ-021 Full FIFO: an emitted event is dropped and overflow is set; a push and pop in the same cycle on a full FIFO both succeed, with no drop.
REQ-022 Empty FIFO plus a simultaneous push: the event appears at t+1; no bypass in the same cycle.
REQ-023 Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-024 An unprefixed 0xE1 byte outside IDLE is treated as a data byte by the current state.

Reset
REQ-025 While reset=1: FSM=IDLE, PAUSE count=0, FIFO empty (ev_valid=0), ev_code=0, ev_ext=0, ev_release=0, ps2_lock_control=3'b000, held bits=0, last_code=8'h00, overflow=0.
REQ-026 While reset=1, the key_action edge register loads key_action, so a strobe held high across reset release is not accepted.
REQ-027 Reset mid-sequence (e.g. after E0, or inside PAUSE) discards the partial sequence; the next byte is decoded from IDLE.

Structure
REQ-028 Shared package ps2_pkg holds the FSM state enum and scan-code constants: E0, E1, F0, CAPS=58, NUM=77, SCROLL=7E, FAKE_SHIFT_L=12, FAKE_SHIFT_R=59, and the ignore list.
REQ-029 One sub-module, ps2_event_fifo: synchronous FIFO, 10-bit entries {ext, rel, code}, parameterised depth, full/empty outputs.
REQ-030 Decoder FSM, lock logic and edge detect sit in ps2_key_decoder; no other hierarchy.

Verification
REQ-031 Bytes 1C; F0 1C with ev_ready=1 -> events (1C,0,0) then (1C,0,1); last_code=1C.
REQ-032 Bytes E0 75; E0 F0 75 -> events (75,1,0), (75,1,1); E0 12 -> no event.
REQ-033 Bytes 58,58,58, F0 58, 58 -> caps toggles only on the 1st and 5th make; ps2_lock_control=000 at end; 5 events queued.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event (E1,0,0); num lock unchanged.
REQ-035 ev_ready=0, FIFO_DEPTH=4, 5 make bytes -> 4 events retained in order, overflow=1; push with pop at full -> no drop.
REQ-036 Reset pulsed after byte E0, key_action held high through release -> no byte accepted; next 1C yields (1C,0,0).
